// File: rtl/watchdog_reset.sv
`default_nettype none
// ============================================================================
//  Module      : watchdog_reset
//  Description : System reset generator. Stretches the external power-on
//                reset to a fixed minimum length and runs a kickable
//                watchdog that forces a fixed-length system reset on
//                timeout before releasing and re-arming.
//  Revision    : 1.0 - initial release
// ============================================================================
module watchdog_reset #(
   parameter int HOLD_CYCLES = 16,       // reset low time, >= 1
   parameter int PRESCALE    = 393216,   // clocks per watchdog tick, >= 2
   parameter int WD_LIMIT    = 8         // ticks without a kick before firing, >= 1
) (
   input  logic CLK_24MB,
   input  logic RESET,        // synchronous, active-low
   input  logic WD_EN,
   input  logic WD_KICK,
   output logic nRESET_OUT,   // active-low system reset, registered
   output logic WD_FIRED      // sticky watchdog-fired flag
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int TICK_W = $clog2(WD_LIMIT + 1);

   // Terminal values: each counter stops at or before these, never wraps blindly
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WD_LIMIT - 1);

   typedef enum logic [1:0] {
      POR_HOLD = 2'd0,
      RUN      = 2'd1,
      WD_HOLD  = 2'd2
   } state_t;

   state_t             state;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [PRE_W-1:0]   pre_cnt;
   logic [TICK_W-1:0]  tick_cnt;

   // Reset sequencing FSM: hold phases, watchdog prescaler/tick counting, outputs
   always_ff @(posedge CLK_24MB) begin
      if (!RESET) begin
         state      <= POR_HOLD;
         hold_cnt   <= '0;
         pre_cnt    <= '0;
         tick_cnt   <= '0;
         nRESET_OUT <= 1'b0;
         WD_FIRED   <= 1'b0;
      end else begin
         case (state)
            // Both hold phases count identically; kick and enable are ignored here
            POR_HOLD, WD_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state      <= RUN;
                  nRESET_OUT <= 1'b1;
                  hold_cnt   <= '0;
                  pre_cnt    <= '0;
                  tick_cnt   <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            RUN: begin
               // A kick outranks everything, including a fire on this same edge
               if (WD_KICK || !WD_EN) begin
                  pre_cnt  <= '0;
                  tick_cnt <= '0;
               end else if (pre_cnt == PRE_LAST) begin
                  pre_cnt <= '0;
                  if (tick_cnt == TICK_LAST) begin
                     // Incrementing would reach WD_LIMIT: fire instead of counting
                     state      <= WD_HOLD;
                     nRESET_OUT <= 1'b0;
                     WD_FIRED   <= 1'b1;
                     hold_cnt   <= '0;
                     tick_cnt   <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end else begin
                  pre_cnt <= pre_cnt + 1'b1;
               end
            end

            default: begin
               state      <= POR_HOLD;
               hold_cnt   <= '0;
               pre_cnt    <= '0;
               tick_cnt   <= '0;
               nRESET_OUT <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_watchdog_reset.sv
`default_nettype none
// ============================================================================
//  Module      : tb_watchdog_reset
//  Description : Self-checking bench for watchdog_reset. Directed timing
//                scenarios plus randomized stimulus, all compared against
//                a time-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_watchdog_reset;

   localparam int HOLD    = 4;
   localparam int PRE     = 8;
   localparam int LIMIT   = 3;
   localparam int TIMEOUT = PRE * LIMIT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wd_en = 1'b0;
   logic wd_kick = 1'b0;
   logic nreset_out;
   logic wd_fired;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a phase plus the number of cycles spent in it
   int   m_mode = 0;      // 0 power-on hold, 1 running, 2 watchdog hold
   int   m_elapsed = 0;
   logic m_nres = 1'b0;
   logic m_fired = 1'b0;

   watchdog_reset #(
      .HOLD_CYCLES (HOLD),
      .PRESCALE    (PRE),
      .WD_LIMIT    (LIMIT)
   ) dut (
      .CLK_24MB   (clk),
      .RESET      (rst_n),
      .WD_EN      (wd_en),
      .WD_KICK    (wd_kick),
      .nRESET_OUT (nreset_out),
      .WD_FIRED   (wd_fired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the timing rules directly
   task automatic model_step(input logic r, input logic e, input logic k);
      if (!r) begin
         m_mode = 0; m_elapsed = 0; m_nres = 1'b0; m_fired = 1'b0;
      end else if (m_mode != 1) begin
         m_elapsed++;
         if (m_elapsed == HOLD) begin
            m_mode = 1; m_elapsed = 0; m_nres = 1'b1;
         end
      end else if (k || !e) begin
         m_elapsed = 0;
      end else begin
         m_elapsed++;
         if (m_elapsed == TIMEOUT) begin
            m_mode = 2; m_elapsed = 0; m_nres = 1'b0; m_fired = 1'b1;
         end
      end
   endtask

   // One clock with given inputs; outputs compared with the model 1 time unit after the edge
   task automatic cycle(input logic r, input logic e, input logic k);
      rst_n = r; wd_en = e; wd_kick = k;
      @(posedge clk);
      model_step(r, e, k);
      #1;
      check("nreset_model", nreset_out, m_nres);
      check("fired_model", wd_fired, m_fired);
   endtask

   // Count edges until nRESET_OUT reaches the given level; -1 if the bound expires
   task automatic wait_level(input logic level, input logic e, input logic k, output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         cycle(1'b1, e, k);
         if (nreset_out === level) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic power_on(input string tag);
      for (int i = 0; i < HOLD; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         check({tag, "_por_nres"}, nreset_out, (i == HOLD - 1) ? 1 : 0);
         check({tag, "_por_fired"}, wd_fired, 0);
      end
   endtask

   initial begin
      int n;
      // Power-on
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
      check("rst_nres", nreset_out, 0);
      check("rst_fired", wd_fired, 0);
      power_on("p1");

      // Timeout, hold length with kicks ignored, second timeout
      wait_level(1'b0, 1'b1, 1'b0, n);
      check("timeout1_len", n, TIMEOUT);
      check("timeout1_fired", wd_fired, 1);
      wait_level(1'b1, 1'b1, 1'b1, n);
      check("hold_len_kicked", n, HOLD);
      wait_level(1'b0, 1'b1, 1'b0, n);
      check("timeout2_len", n, TIMEOUT);
      check("timeout2_fired", wd_fired, 1);

      // Mid-hold reset clears the sticky flag; power-on timing repeats
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      check("midhold_nres", nreset_out, 0);
      check("midhold_fired", wd_fired, 0);
      power_on("p2");

      // Regular kicks keep the system alive
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, 1'b1, (i % 20) == 19);
         check("kick_alive", nreset_out, 1);
      end
      check("kick_fired", wd_fired, 0);

      // Kick on the exact firing edge wins; full timeout follows
      for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      check("edge_kick_nres", nreset_out, 1);
      check("edge_kick_fired", wd_fired, 0);
      wait_level(1'b0, 1'b1, 1'b0, n);
      check("after_edge_kick_len", n, TIMEOUT);
      wait_level(1'b1, 1'b1, 1'b0, n);
      check("hold_len", n, HOLD);

      // Disabled watchdog never fires; re-enable needs a full timeout
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, (i == 10) ? 1'b1 : 1'b0, 1'b0);
         check("disabled_alive", nreset_out, 1);
      end
      wait_level(1'b0, 1'b1, 1'b0, n);
      check("enable_timeout_len", n, TIMEOUT);

      // Randomized stimulus against the model
      begin
         logic e = 1'b1;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(59) == 0) e = ~e;
            cycle(($urandom_range(299) == 0) ? 1'b0 : 1'b1, e, ($urandom_range(39) == 0) ? 1'b1 : 1'b0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
